// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: PC, one AXI4-Lite read per instruction, {pc, inst} to decode.
// Optional performance counters are built when YSYX_25020037_IFU_PERF_EN is defined.
module ysyx_25020037_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        ifu_valid,
  input  logic        idu_ready,
  output logic [63:0] fu_to_du_bus,
  output logic        ifu_err,
  input  logic        exu_dnpc_valid,
  input  logic [31:0] exu_dnpc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] fetch_addr;
  logic        discard, discard_nxt;
  logic [31:0] inst_q, inst_pc_q;
  logic        err_q;
  logic        take_data;
  logic        dec_fire;

  assign take_data = (state == S_WAIT) & rvalid & ~discard & ~exu_dnpc_valid;
  assign dec_fire  = (state == S_HOLD) & idu_ready;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    if (exu_dnpc_valid) pc_nxt = exu_dnpc;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        // The in-flight request keeps its old address; its response is dropped later.
        if (exu_dnpc_valid) discard_nxt = 1'b1;
        if (arready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rvalid) begin
          discard_nxt = 1'b0;
          state_nxt   = (discard | exu_dnpc_valid) ? S_REQ : S_HOLD;
        end else if (exu_dnpc_valid) begin
          discard_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (exu_dnpc_valid) begin
          state_nxt = S_REQ;
        end else if (idu_ready) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      discard    <= 1'b0;
      inst_q     <= 32'h0;
      inst_pc_q  <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
      // Fetch address is captured only on entry to REQ so araddr holds until accepted.
      if ((state != S_REQ) && (state_nxt == S_REQ)) fetch_addr <= pc_nxt;
      if (take_data) begin
        inst_q    <= rdata;
        inst_pc_q <= fetch_addr;
        err_q     <= (rresp != 2'b00);
      end
    end
  end

  assign araddr       = fetch_addr;
  assign arvalid      = (state == S_REQ);
  assign rready       = (state == S_WAIT);
  assign ifu_valid    = (state == S_HOLD);
  assign fu_to_du_bus = {inst_pc_q, inst_q};
  assign ifu_err      = err_q;

`ifdef YSYX_25020037_IFU_PERF_EN
  logic [31:0] fetch_cnt_q, wait_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      wait_cnt_q  <= 32'h0;
    end else begin
      if (dec_fire) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state == S_WAIT) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_wait_cnt  = wait_cnt_q;
`else
  logic unused_perf;
  assign unused_perf    = dec_fire;
  assign perf_fetch_cnt = 32'h0;
  assign perf_wait_cnt  = 32'h0;
`endif

endmodule

// File: doc/ysyx_25020037_ifu.md
# ysyx_25020037_ifu

Instruction fetch unit: holds the PC, reads one 32-bit instruction per fetch over an AXI4-Lite read channel, and presents `{pc, inst}` to the decode stage under a valid/ready handshake. It is the upstream end of the fetch-to-decode interface. It sits between the instruction bus (or I-cache) and the decode stage, and takes PC redirects from the execute stage.

## Interface
- `RESET_PC`, 32'h3000_0000, PC loaded on reset.
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `araddr`  out  32  read address
- `arvalid`  out  1  read address valid
- `arready`  in  1  read address accepted
- `rdata`  in  32  read data
- `rresp`  in  2  read response; nonzero = error
- `rvalid`  in  1  read data valid
- `rready`  out  1  read data ready
- `ifu_valid`  out  1  `fu_to_du_bus` holds a valid instruction
- `idu_ready`  in  1  decode accepts this cycle
- `fu_to_du_bus`  out  64  `{pc[31:0], inst[31:0]}`, pc in the MSBs
- `ifu_err`  out  1  current `fu_to_du_bus` beat came from an error response
- `exu_dnpc_valid`  in  1  execute-stage redirect strobe (single cycle)
- `exu_dnpc`  in  32  redirect target
- `perf_fetch_cnt`  out  32  instructions handed to decode
- `perf_wait_cnt`  out  32  cycles spent in WAIT

## Operation
- States: IDLE, REQ, WAIT, HOLD. Reset enters IDLE.
- IDLE: all handshake outputs are 0. Next cycle goes to REQ.
- REQ:
  - `arvalid`=1, `araddr`=`fetch_addr`; `fetch_addr` is latched from `pc` on entry to REQ.
  - On `arvalid & arready`, go to WAIT.
  - `araddr` must stay stable while `arvalid` is high and not yet accepted.
- WAIT: `rready`=1. On `rvalid`:
  - If `discard`=1, or `exu_dnpc_valid` is high this cycle: drop the data, clear `discard`, go to REQ.
  - Otherwise: latch `inst`=`rdata`, `ifu_err`=(`rresp`!=0), go to HOLD.
- HOLD: `ifu_valid`=1. `fu_to_du_bus` and `ifu_err` stay stable until the handshake.
  - On `ifu_valid & idu_ready`: `pc`<=`pc`+4 (mod 2^32, wraps silently), go to REQ.
- Redirect (`exu_dnpc_valid`=1) by state:
  - Any state: `pc`<=`exu_dnpc`.
  - REQ: the request in flight keeps the old `fetch_addr`. Set `discard`; the response is dropped later in WAIT.
  - WAIT without `rvalid`: set `discard`.
  - HOLD: `ifu_valid` drops next cycle, go to REQ. If `idu_ready` is high in the same cycle, the handshake counts; decode kills that beat itself. `pc` takes `exu_dnpc`, not `pc`+4.
  - IDLE: only `pc` is updated.
- A redirect arriving with a `rvalid` in the same cycle: the redirect wins. Data is dropped and the next fetch uses `exu_dnpc`.
- `rresp` error: the instruction word is still forwarded as received. `ifu_err` flags it.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `fetch_addr`=`RESET_PC`, `araddr`=`RESET_PC`.
  - `arvalid`=0, `rready`=0, `ifu_valid`=0, `ifu_err`=0, `discard`=0.
  - `fu_to_du_bus`=64'h0, both perf counters 0.
- All outputs are registered or decoded from state only. There is no combinational path from `idu_ready` or `rvalid` to any output.
- Best case, with `arready` high in REQ and `rvalid` on the next cycle:
  - REQ at cycle N, WAIT at N+1, `ifu_valid` at N+2.
  - With `idu_ready` high, REQ resumes at N+3: one instruction per 3 cycles.
- Redirect to first fetch of the target:
  - From HOLD: `arvalid` for the target 1 cycle after the redirect.
  - From REQ or WAIT: after the discarded response returns, plus 1 cycle.
- Reset asserted mid-transaction returns to IDLE on the next edge. The bus is reset together with this block, so outstanding bus state is discarded.

## Configuration
- `YSYX_25020037_IFU_PERF_EN` defined:
  - `perf_fetch_cnt` increments on each `ifu_valid & idu_ready`.
  - `perf_wait_cnt` increments on each cycle in WAIT.
  - Both are 32-bit, wrap, and clear on reset.
- Not defined: both ports are tied to 32'h0 and the counters are not built. Functional behaviour is otherwise identical.

## Test plan
- Reset, then memory with `arready`=1 and a 1-cycle `rvalid` latency → `araddr`=0x3000_0000 at cycle 1; `ifu_valid` with bus {0x3000_0000, `rdata`} at cycle 3; next `araddr`=0x3000_0004.
- `idu_ready`=0 for 5 cycles in HOLD → `ifu_valid` stays high; bus unchanged; no new `arvalid`.
- Redirect to 0x8000_0000 while in WAIT, `rvalid` 2 cycles later → that data is never presented; next `araddr`=0x8000_0000.
- Redirect to 0x8000_0100 in HOLD, same cycle as `idu_ready`=1 → next `araddr`=0x8000_0100, not pc+4.
- `arready` held low for 4 cycles while a redirect arrives → `araddr` stays at the old value until accepted; the response is discarded.
- `rresp`=2'b10 → beat presented with `ifu_err`=1. With the macro defined, after 10 accepted fetches `perf_fetch_cnt`=10.
